// File: rtl/note_mixer.sv
// note_mixer: NUM_CH square-wave voices with shared volume, summed with
// saturation into one signed AMP_W-bit sample per sample_tick.
// Optional build macro NOTE_MIXER_ENVELOPE_EN adds a per-voice linear
// attack/release envelope with a release tail on the last divider.
module note_mixer #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 22,
  parameter int AMP_W  = 16,
  parameter int VOL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] note_div,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [VOL_W-1:0]        volume,
  input  logic                    sample_tick,
  output logic [AMP_W-1:0]        audio_out,
  output logic                    out_valid,
  output logic [NUM_CH-1:0]       active
);

  localparam int SUM_W = AMP_W + $clog2(NUM_CH) + 1;
  localparam logic signed [SUM_W-1:0] MAXV = {{(SUM_W-AMP_W+1){1'b0}}, {(AMP_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MINV = {{(SUM_W-AMP_W+1){1'b1}}, {(AMP_W-1){1'b0}}};

  logic [DIV_W-1:0]        divIn   [NUM_CH];
  logic [DIV_W-1:0]        effDiv  [NUM_CH];
  logic [DIV_W-1:0]        cnt_q   [NUM_CH];
  logic [DIV_W-1:0]        cnt_d   [NUM_CH];
  logic [NUM_CH-1:0]       phase_q, phase_d;
  logic [NUM_CH-1:0]       active_q, active_d;
  logic [NUM_CH-1:0]       sounding, running;
  logic signed [SUM_W-1:0] amp;
  logic signed [SUM_W-1:0] contrib [NUM_CH];
  logic signed [SUM_W-1:0] mixSum;
  logic [AMP_W-1:0]        satSum;
  logic [AMP_W-1:0]        audio_q;
  logic                    valid_q;

  // Unpack per-voice dividers and decide which voices are sounding right now
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      divIn[i]    = note_div[i*DIV_W +: DIV_W];
      sounding[i] = ch_en[i] && (divIn[i] >= DIV_W'(2));
    end
  end

`ifdef NOTE_MIXER_ENVELOPE_EN
  localparam int ENV_W  = VOL_W + 3;
  localparam int PROD_W = SUM_W + ENV_W;

  logic [ENV_W-1:0]  env_q     [NUM_CH];
  logic [ENV_W-1:0]  env_d     [NUM_CH];
  logic [DIV_W-1:0]  lastDiv_q [NUM_CH];
  logic [DIV_W-1:0]  lastDiv_d [NUM_CH];
  logic [PROD_W-1:0] envProd   [NUM_CH];

  // Envelope ramps once per tick; a released voice keeps ringing on its last divider
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      env_d[i]     = env_q[i];
      lastDiv_d[i] = sounding[i] ? divIn[i] : lastDiv_q[i];
      if (sample_tick) begin
        if (sounding[i] && (env_q[i] != {ENV_W{1'b1}}))
          env_d[i] = env_q[i] + ENV_W'(1);
        else if (!sounding[i] && (env_q[i] != '0))
          env_d[i] = env_q[i] - ENV_W'(1);
      end
      running[i]  = sounding[i] || (env_q[i] != '0);
      effDiv[i]   = sounding[i] ? divIn[i] : lastDiv_q[i];
      active_d[i] = (env_d[i] != '0);
    end
  end

  // Envelope and remembered divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        env_q[i]     <= '0;
        lastDiv_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        env_q[i]     <= env_d[i];
        lastDiv_q[i] <= lastDiv_d[i];
      end
    end
  end

  // Envelope-scaled contribution, sign taken from the voice phase
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      envProd[i] = (PROD_W'(amp) * PROD_W'(env_q[i])) >> ENV_W;
      contrib[i] = phase_q[i] ? -SUM_W'(envProd[i]) : SUM_W'(envProd[i]);
    end
  end
`else
  // Without the envelope, voices run and sound only while enabled
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      running[i]  = sounding[i];
      effDiv[i]   = divIn[i];
      active_d[i] = sounding[i];
      if (!sounding[i])
        contrib[i] = '0;
      else
        contrib[i] = phase_q[i] ? -amp : amp;
    end
  end
`endif

  // Half-period counters; >= keeps a lowered divider from letting the count wrap
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]   = cnt_q[i] + DIV_W'(1);
      phase_d[i] = phase_q[i];
      if (!running[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (cnt_q[i] >= effDiv[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = ~phase_q[i];
      end
    end
  end

  // Voice state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      phase_q  <= '0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      phase_q  <= phase_d;
      active_q <= active_d;
    end
  end

  // Shared amplitude, signed sum of all voices, then clamp to the sample range
  always_comb begin
    amp    = (SUM_W'(volume) + SUM_W'(1)) << (AMP_W - 7);
    mixSum = '0;
    for (int i = 0; i < NUM_CH; i++) mixSum = mixSum + contrib[i];
    if (mixSum > MAXV)
      satSum = AMP_W'(MAXV);
    else if (mixSum < MINV)
      satSum = AMP_W'(MINV);
    else
      satSum = AMP_W'(mixSum);
  end

  // Output sample register, loaded only on a tick and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= sample_tick;
      if (sample_tick) audio_q <= satSum;
    end
  end

  assign audio_out = audio_q;
  assign out_valid = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_note_mixer.sv
// tb_note_mixer: directed scoreboard bench for note_mixer.
// Instance A has two voices, instance B has sixteen for saturation.
module tb_note_mixer;

  logic                clk;
  logic                rst;
  logic [43:0]         divA;
  logic [1:0]          enA;
  logic [2:0]          volA;
  logic                tickA;
  logic [15:0]         audioA;
  logic                validA;
  logic [1:0]          activeA;
  logic [351:0]        divB;
  logic [15:0]         enB;
  logic [2:0]          volB;
  logic                tickB;
  logic [15:0]         audioB;
  logic                validB;
  logic [15:0]         activeB;

  logic signed [15:0]  qA[$];
  logic signed [15:0]  qB[$];
  logic signed [15:0]  expA, expB;
  int                  checks = 0;
  int                  errors = 0;

  note_mixer #(.NUM_CH(2), .DIV_W(22), .AMP_W(16), .VOL_W(3)) dutA (
    .clk(clk), .rst(rst), .note_div(divA), .ch_en(enA), .volume(volA),
    .sample_tick(tickA), .audio_out(audioA), .out_valid(validA), .active(activeA)
  );

  note_mixer #(.NUM_CH(16), .DIV_W(22), .AMP_W(16), .VOL_W(3)) dutB (
    .clk(clk), .rst(rst), .note_div(divB), .ch_en(enB), .volume(volB),
    .sample_tick(tickB), .audio_out(audioB), .out_valid(validB), .active(activeB)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Direct comparison with bookkeeping
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive instance A for one cycle, queueing the expected sample when ticking
  task automatic applyStimulus(input logic [1:0] en, input logic [21:0] d0, input logic [21:0] d1,
                               input logic [2:0] vol, input logic tick, input logic signed [15:0] expVal);
    enA   = en;
    divA  = {d1, d0};
    volA  = vol;
    tickA = tick;
    if (tick) qA.push_back(expVal);
    @(negedge clk);
  endtask

  // Monitor for instance A: every valid sample must match the oldest expectation
  always begin
    @(posedge clk);
    #1;
    if (validA) begin
      checks++;
      if (qA.size() == 0) begin
        errors++;
        $display("[TB] FAIL sampleA unexpected valid actual=%0d expected=none", $signed(audioA));
      end else begin
        expA = qA.pop_front();
        if (audioA !== expA) begin
          errors++;
          $display("[TB] FAIL sampleA actual=%0d expected=%0d", $signed(audioA), expA);
        end
      end
    end
  end

  // Monitor for instance B
  always begin
    @(posedge clk);
    #1;
    if (validB) begin
      checks++;
      if (qB.size() == 0) begin
        errors++;
        $display("[TB] FAIL sampleB unexpected valid actual=%0d expected=none", $signed(audioB));
      end else begin
        expB = qB.pop_front();
        if (audioB !== expB) begin
          errors++;
          $display("[TB] FAIL sampleB actual=%0d expected=%0d", $signed(audioB), expB);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    enA = '0; divA = '0; volA = '0; tickA = 1'b0;
    enB = '0; divB = '0; volB = '0; tickB = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state with no ticks
    checkOutput("resetAudioA", 32'(audioA), 32'd0);
    checkOutput("resetValidA", 32'(validA), 32'd0);
    checkOutput("resetActiveA", 32'(activeA), 32'd0);
    checkOutput("resetAudioB", 32'(audioB), 32'd0);
    checkOutput("resetActiveB", 32'(activeB), 32'd0);

    // One voice, div 3, full volume, tick every cycle: 4 high, 4 low
    for (int c = 0; c < 16; c++)
      applyStimulus(2'b01, 22'd3, 22'd0, 3'd7, 1'b1, ((c % 8) < 4) ? 16'sd4096 : -16'sd4096);
    checkOutput("activeOneVoice", 32'(activeA), 32'h1);

    // Two voices in phase at minimum volume, single tick one cycle after enable
    applyStimulus(2'b00, 22'd0, 22'd0, 3'd0, 1'b0, 16'sd0);
    applyStimulus(2'b00, 22'd0, 22'd0, 3'd0, 1'b0, 16'sd0);
    applyStimulus(2'b11, 22'd5, 22'd5, 3'd0, 1'b0, 16'sd0);
    applyStimulus(2'b11, 22'd5, 22'd5, 3'd0, 1'b1, 16'sd1024);
    for (int c = 0; c < 3; c++)
      applyStimulus(2'b11, 22'd5, 22'd5, 3'd0, 1'b0, 16'sd0);
    checkOutput("holdAudio", 32'(audioA), 32'h400);
    checkOutput("validPulse", 32'(validA), 32'd0);
    checkOutput("activeTwoVoices", 32'(activeA), 32'h3);

    // Divider lowered mid-note from 100 to 20 at count 60
    applyStimulus(2'b00, 22'd0, 22'd0, 3'd7, 1'b0, 16'sd0);
    applyStimulus(2'b00, 22'd0, 22'd0, 3'd7, 1'b0, 16'sd0);
    for (int c = 0; c < 90; c++) begin
      case (c)
        60:      applyStimulus(2'b01, 22'd20, 22'd0, 3'd7, 1'b1, 16'sd4096);
        61:      applyStimulus(2'b01, 22'd20, 22'd0, 3'd7, 1'b1, -16'sd4096);
        81:      applyStimulus(2'b01, 22'd20, 22'd0, 3'd7, 1'b1, -16'sd4096);
        82:      applyStimulus(2'b01, 22'd20, 22'd0, 3'd7, 1'b1, 16'sd4096);
        default: applyStimulus(2'b01, (c < 60) ? 22'd100 : 22'd20, 22'd0, 3'd7, 1'b0, 16'sd0);
      endcase
    end

    // Divider 1 and 0 are silent even when enabled
    applyStimulus(2'b01, 22'd1, 22'd0, 3'd7, 1'b1, 16'sd0);
    applyStimulus(2'b01, 22'd1, 22'd0, 3'd7, 1'b0, 16'sd0);
    checkOutput("silentActive", 32'(activeA), 32'd0);
    applyStimulus(2'b11, 22'd1, 22'd0, 3'd7, 1'b1, 16'sd0);

    // Divider 2 is the smallest sounding value: 3 cycles per half period
    applyStimulus(2'b01, 22'd2, 22'd0, 3'd7, 1'b1, 16'sd4096);
    applyStimulus(2'b01, 22'd2, 22'd0, 3'd7, 1'b1, 16'sd4096);
    applyStimulus(2'b01, 22'd2, 22'd0, 3'd7, 1'b1, 16'sd4096);
    applyStimulus(2'b01, 22'd2, 22'd0, 3'd7, 1'b1, -16'sd4096);
    applyStimulus(2'b00, 22'd0, 22'd0, 3'd7, 1'b0, 16'sd0);

    // Sixteen voices at full volume saturate both ways, then unsaturated at volume 0
    enB = 16'hFFFF;
    for (int i = 0; i < 16; i++) divB[i*22 +: 22] = 22'd10;
    volB  = 3'd7;
    tickB = 1'b1;
    qB.push_back(16'sd32767);
    @(negedge clk);
    tickB = 1'b0;
    repeat (10) @(negedge clk);
    tickB = 1'b1;
    qB.push_back(-16'sd32768);
    @(negedge clk);
    tickB = 1'b0;
    repeat (10) @(negedge clk);
    volB  = 3'd0;
    tickB = 1'b1;
    qB.push_back(16'sd8192);
    @(negedge clk);
    tickB = 1'b0;
    checkOutput("activeAllB", 32'(activeB), 32'hFFFF);

    // Reset asserted mid-note clears everything without waiting for a clock edge
    applyStimulus(2'b01, 22'd3, 22'd0, 3'd7, 1'b1, 16'sd4096);
    applyStimulus(2'b01, 22'd3, 22'd0, 3'd7, 1'b0, 16'sd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstAudioA", 32'(audioA), 32'd0);
    checkOutput("asyncRstActiveA", 32'(activeA), 32'd0);
    checkOutput("asyncRstAudioB", 32'(audioB), 32'd0);
    checkOutput("asyncRstActiveB", 32'(activeB), 32'd0);
    @(negedge clk);
    applyStimulus(2'b01, 22'd3, 22'd0, 3'd7, 1'b0, 16'sd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++)
      applyStimulus(2'b01, 22'd3, 22'd0, 3'd7, 1'b0, 16'sd0);
    checkOutput("postRstAudioA", 32'(audioA), 32'd0);
    checkOutput("postRstActiveA", 32'(activeA), 32'h1);

    // Every queued expectation must have been matched by a DUT sample
    for (int k = 0; k < 20 && (qA.size() != 0 || qB.size() != 0); k++) @(negedge clk);
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pendingA=%0d pendingB=%0d expected=0", qA.size(), qB.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
